instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Program-counter and instruction-fetch stage that feeds the Control decoder in the single-cycle core.
- Holds the PC and drives the instruction-memory address. It presents the fetched instruction, and the opcode field Control decodes.
- Next PC is either sequential or a branch target, using Control's qualified Branch output and a 16-entry branch-target LUT.
- A start/done handshake brackets each program run, and a cycle counter reports execution time.

Parameters:
PC_W, 10, program counter / instruction memory address width
INSTR_W, 9, instruction width; opcode = instr[INSTR_W-1 -: 4]
LUT_AW, 4, branch-target LUT index width (2^LUT_AW entries); index = instr[LUT_AW-1:0]
START_PC, 0, PC loaded on start
HALT_INSTR, 9'h1FF, encoding that ends a run
CNT_W, 16, cycle counter width

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a run (sampled in IDLE/HALT)
branch  input  1  from Control Branch (already qualified by equal); take LUT target
imem_addr  output  PC_W  instruction memory address (= pc)
imem_data  input  INSTR_W  combinational instruction memory read data
instr  output  INSTR_W  instruction to datapath; imem_data in RUN, else NOP
opcode  output  4  instr[INSTR_W-1 -: 4], to Control instr port
running  output  1  high while state == RUN
done  output  1  sticky high in HALT
pc  output  PC_W  current program counter
cycle_count  output  CNT_W  RUN cycles of last/current run
lut_we  input  1  write enable for branch-target LUT
lut_waddr  input  LUT_AW  LUT write index
lut_wdata  input  PC_W  LUT write data (absolute target PC)

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE, pc=0, cycle_count=0, done=0, running=0.
  - All LUT entries are 0.
  - instr = NOP.
- NOP encoding: opcode 4'b1111, remaining bits 0. Control decodes it with RegWrite=0, MemWrite=0, Branch=0.
- States: IDLE, RUN, HALT.
  - IDLE: start=1 -> RUN next cycle; pc<=START_PC, cycle_count<=0.
  - RUN, imem_data==HALT_INSTR: -> HALT; pc holds; this cycle counts.
    - Else if branch=1: pc <= LUT[imem_data[LUT_AW-1:0]].
    - Else: pc <= pc+1, wrapping modulo 2^PC_W (max -> 0, no flag).
  - HALT: done=1, pc holds. start=1 -> RUN: pc<=START_PC, cycle_count<=0, done<=0 at that edge.
- start is ignored in RUN.
- branch is ignored outside RUN and on the HALT_INSTR cycle.
- Fetch is combinational: imem_addr=pc.
  - instr=imem_data only when state==RUN, else NOP.
  - One instruction completes per RUN cycle; the first instruction is at START_PC in the first RUN cycle.
- cycle_count:
  - +1 every RUN cycle, including the halt-detect cycle.
  - Saturates at all-ones.
  - Holds in HALT/IDLE.
- LUT:
  - Written on the clk edge when lut_we=1, in any state.
  - Read is combinational.
  - On a same-cycle write and branch to the same index, the branch uses the old value.
- Reset asserted mid-run: immediate return to reset values; the run is lost; LUT is cleared.
- running/done are registered state decodes; they are never both high.

Test Plan:
- Reset, then hold rst_n=0 -> pc=0, instr=9'h1E0 (NOP), running=0, done=0, cycle_count=0.
- Sequential run:
  - Stimulus: START_PC=0; ROM 0..4 hold ADD-type words; addr 5 holds 9'h1FF; pulse start.
  - Required: pc steps 0,1,2,3,4,5; running high 6 cycles; then done=1, cycle_count=6, pc stays 5.
- Branch taken:
  - Stimulus: LUT[3]=10'd20 loaded before start; ROM addr 2 = 9'h103 (index 3); branch=1 at pc=2.
  - Required: next pc=20; with branch=0 at the same instruction, next pc=3.
- Restart and ignore rules:
  - Pulse start during RUN -> no effect on pc.
  - Pulse start in HALT -> done clears, pc=START_PC, cycle_count restarts at 0.
- Async reset at pc=7 mid-run, between clock edges -> pc=0, state IDLE, LUT[3] reads 0.
- Wrap and LUT hazard:
  - Stimulus: START_PC=1023 with no halt at 1023 -> next pc=0.
  - Stimulus: same-cycle lut_we to index 3 with a branch on index 3 -> old target taken.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: PC register, fetch and next-PC select for the single-cycle core.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start                      begin a run from START_PC (IDLE/HALT only)
//   branch                     qualified Branch from Control
//   imem_addr/imem_data        combinational instruction memory
//   instr/opcode               fetched word (NOP unless RUN) and its opcode
//   running/done               registered RUN / HALT decodes
//   pc, cycle_count            program counter, RUN cycles of the run
//   lut_we/lut_waddr/lut_wdata branch-target LUT write port
module instr_fetch #(
    parameter int                  PC_W       = 10,
    parameter int                  INSTR_W    = 9,
    parameter int                  LUT_AW     = 4,
    parameter logic [PC_W-1:0]     START_PC   = '0,
    parameter logic [INSTR_W-1:0]  HALT_INSTR = 9'h1FF,
    parameter int                  CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               branch,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         opcode,
    output logic               running,
    output logic               done,
    output logic [PC_W-1:0]    pc,
    output logic [CNT_W-1:0]   cycle_count,
    input  logic               lut_we,
    input  logic [LUT_AW-1:0]  lut_waddr,
    input  logic [PC_W-1:0]    lut_wdata
);

    localparam int LUT_N = 1 << LUT_AW;
    localparam logic [INSTR_W-1:0] NOP =
        {4'b1111, {(INSTR_W-4){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [PC_W-1:0]    pc_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [PC_W-1:0]    lut [LUT_N];
    logic               is_halt;
    logic [LUT_AW-1:0]  lut_ridx;

    assign is_halt   = (imem_data == HALT_INSTR);
    assign lut_ridx  = imem_data[LUT_AW-1:0];
    assign imem_addr = pc;
    assign instr     = (state == RUN) ? imem_data : NOP;
    assign opcode    = instr[INSTR_W-1 -: 4];

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        cnt_nxt   = cycle_count;
        unique case (state)
            IDLE, HALT: begin
                if (start) begin
                    state_nxt = RUN;
                    pc_nxt    = START_PC;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                // halt-detect cycle still counts as a RUN cycle
                if (cycle_count != '1)
                    cnt_nxt = cycle_count + 1'b1;
                if (is_halt)
                    state_nxt = HALT;
                else if (branch)
                    pc_nxt = lut[lut_ridx];
                else
                    pc_nxt = pc + 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= '0;
            cycle_count <= '0;
            running     <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            cycle_count <= cnt_nxt;
            running     <= (state_nxt == RUN);
            done        <= (state_nxt == HALT);
        end
    end

    // branch read above sees the pre-write value on a same-edge write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LUT_N; i++)
                lut[i] <= '0;
        end else if (lut_we) begin
            lut[lut_waddr] <= lut_wdata;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed and random checks of instr_fetch
// against a behavioural run/halt model.
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       branch = 1'b0;
    logic [9:0] imem_addr;
    logic [8:0] imem_data;
    logic [8:0] instr;
    logic [3:0] opcode;
    logic       running;
    logic       done;
    logic [9:0] pc;
    logic [15:0] cycle_count;
    logic       lut_we = 1'b0;
    logic [3:0] lut_waddr = '0;
    logic [9:0] lut_wdata = '0;

    logic [8:0] rom [1024];

    int total = 0;
    int bad = 0;

    // model: 0 idle, 1 run, 2 halted
    int         m_mode;
    logic [9:0] m_pc;
    int         m_cnt;
    logic [9:0] m_lut [16];

    always #5 clk = ~clk;

    assign imem_data = rom[imem_addr];

    instr_fetch dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .branch(branch),
        .imem_addr(imem_addr),
        .imem_data(imem_data),
        .instr(instr),
        .opcode(opcode),
        .running(running),
        .done(done),
        .pc(pc),
        .cycle_count(cycle_count),
        .lut_we(lut_we),
        .lut_waddr(lut_waddr),
        .lut_wdata(lut_wdata)
    );

    task automatic model_reset();
        m_mode = 0;
        m_pc = '0;
        m_cnt = 0;
        for (int i = 0; i < 16; i++) m_lut[i] = '0;
    endtask

    task automatic model_step();
        logic [8:0] d;
        d = rom[m_pc];
        if (m_mode == 1) begin
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            if (d == 9'h1FF) m_mode = 2;
            else if (branch) m_pc = m_lut[d[3:0]];
            else m_pc = m_pc + 10'd1;
        end else if (start) begin
            m_mode = 1;
            m_pc = '0;
            m_cnt = 0;
        end
        if (lut_we) m_lut[lut_waddr] = lut_wdata;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic lut_write(input logic [3:0] a, input logic [9:0] v);
        lut_we = 1'b1;
        lut_waddr = a;
        lut_wdata = v;
        tick();
        lut_we = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 1024; i++) rom[i] = 9'h011;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (pc !== 10'd0) begin
            bad++;
            $display("FAIL reset_pc got=%0d exp=0", pc);
        end
        total++;
        if (instr !== 9'h1E0) begin
            bad++;
            $display("FAIL reset_instr got=%h exp=1e0", instr);
        end
        total++;
        if (opcode !== 4'hF) begin
            bad++;
            $display("FAIL reset_opcode got=%h exp=f", opcode);
        end
        total++;
        if (running !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b%b exp=00", running, done);
        end
        total++;
        if (cycle_count !== 16'd0) begin
            bad++;
            $display("FAIL reset_cnt got=%0d exp=0", cycle_count);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 5; i++) rom[i] = 9'(9'h010 + i);
        rom[5] = 9'h1FF;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            total++;
            if (running !== 1'b1 || pc !== 10'(k)) begin
                bad++;
                $display("FAIL seq_step k=%0d got pc=%0d run=%b exp pc=%0d run=1",
                         k, pc, running, k);
            end
            total++;
            if (instr !== rom[k]) begin
                bad++;
                $display("FAIL seq_instr k=%0d got=%h exp=%h", k, instr, rom[k]);
            end
            tick();
        end
        total++;
        if (done !== 1'b1 || running !== 1'b0) begin
            bad++;
            $display("FAIL seq_done got run=%b done=%b exp 0 1", running, done);
        end
        total++;
        if (cycle_count !== 16'd6) begin
            bad++;
            $display("FAIL seq_cnt got=%0d exp=6", cycle_count);
        end
        tick();
        total++;
        if (pc !== 10'd5 || done !== 1'b1) begin
            bad++;
            $display("FAIL seq_hold got pc=%0d done=%b exp 5 1", pc, done);
        end
    endtask

    task automatic test_branch();
        lut_write(4'd3, 10'd20);
        rom[0] = 9'h011;
        rom[1] = 9'h012;
        rom[2] = 9'h103;
        rom[3] = 9'h1FF;
        rom[20] = 9'h1FF;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (done !== 1'b0 || pc !== 10'd0 || cycle_count !== 16'd0) begin
            bad++;
            $display("FAIL restart got done=%b pc=%0d cnt=%0d exp 0 0 0",
                     done, pc, cycle_count);
        end
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (pc !== 10'd2 || running !== 1'b1) begin
            bad++;
            $display("FAIL start_in_run got pc=%0d run=%b exp 2 1", pc, running);
        end
        branch = 1'b1;
        tick();
        branch = 1'b0;
        total++;
        if (pc !== 10'd20) begin
            bad++;
            $display("FAIL br_taken got=%0d exp=20", pc);
        end
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        total++;
        if (pc !== 10'd3) begin
            bad++;
            $display("FAIL br_not_taken got=%0d exp=3", pc);
        end
        tick();
        total++;
        if (done !== 1'b1 || cycle_count !== 16'd4) begin
            bad++;
            $display("FAIL br_halt got done=%b cnt=%0d exp 1 4", done, cycle_count);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 8; i++) rom[i] = 9'(9'h020 + i);
        rom[8] = 9'h1FF;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        total++;
        if (pc !== 10'd7) begin
            bad++;
            $display("FAIL ar_pre got=%0d exp=7", pc);
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        total++;
        if (pc !== 10'd0 || running !== 1'b0 || cycle_count !== 16'd0
            || instr !== 9'h1E0) begin
            bad++;
            $display("FAIL ar_now got pc=%0d run=%b cnt=%0d instr=%h exp 0 0 0 1e0",
                     pc, running, cycle_count, instr);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (running !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL ar_idle got run=%b done=%b exp 0 0", running, done);
        end
        rom[0] = 9'h103;
        rom[1] = 9'h1FF;
        start = 1'b1;
        tick();
        start = 1'b0;
        branch = 1'b1;
        rom[1] = 9'h011;
        rom[2] = 9'h1FF;
        tick();
        branch = 1'b0;
        total++;
        if (pc !== 10'd0) begin
            bad++;
            $display("FAIL ar_lut_clear got=%0d exp=0", pc);
        end
        repeat (3) tick();
    endtask

    task automatic test_wrap_hazard();
        lut_write(4'd5, 10'd1023);
        lut_write(4'd3, 10'd30);
        rom[0] = 9'h105;
        rom[1] = 9'h1FF;
        rom[1023] = 9'h033;
        start = 1'b1;
        tick();
        start = 1'b0;
        branch = 1'b1;
        tick();
        branch = 1'b0;
        total++;
        if (pc !== 10'd1023) begin
            bad++;
            $display("FAIL wrap_pre got=%0d exp=1023", pc);
        end
        tick();
        total++;
        if (pc !== 10'd0 || running !== 1'b1) begin
            bad++;
            $display("FAIL wrap got pc=%0d run=%b exp 0 1", pc, running);
        end
        tick();
        tick();
        rom[0] = 9'h103;
        rom[30] = 9'h103;
        rom[40] = 9'h1FF;
        start = 1'b1;
        tick();
        start = 1'b0;
        branch = 1'b1;
        lut_we = 1'b1;
        lut_waddr = 4'd3;
        lut_wdata = 10'd40;
        tick();
        lut_we = 1'b0;
        total++;
        if (pc !== 10'd30) begin
            bad++;
            $display("FAIL hazard_old got=%0d exp=30", pc);
        end
        tick();
        branch = 1'b0;
        total++;
        if (pc !== 10'd40) begin
            bad++;
            $display("FAIL hazard_new got=%0d exp=40", pc);
        end
        tick();
    endtask

    task automatic test_random();
        logic [8:0] exp_i;
        for (int i = 0; i < 1024; i++)
            rom[i] = ($urandom_range(0, 15) == 0) ? 9'h1FF : 9'($urandom);
        for (int c = 0; c < 600; c++) begin
            start = ($urandom_range(0, 7) == 0);
            branch = $urandom_range(0, 1) == 1;
            lut_we = ($urandom_range(0, 3) == 0);
            lut_waddr = 4'($urandom);
            lut_wdata = 10'($urandom);
            tick();
            exp_i = (m_mode == 1) ? rom[m_pc] : 9'h1E0;
            total++;
            if (pc !== m_pc || cycle_count !== 16'(m_cnt)) begin
                bad++;
                $display("FAIL rnd_pc_cnt c=%0d got pc=%0d cnt=%0d exp pc=%0d cnt=%0d",
                         c, pc, cycle_count, m_pc, m_cnt);
            end
            total++;
            if (running !== (m_mode == 1) || done !== (m_mode == 2)) begin
                bad++;
                $display("FAIL rnd_state c=%0d got run=%b done=%b exp mode=%0d",
                         c, running, done, m_mode);
            end
            total++;
            if (instr !== exp_i || opcode !== exp_i[8:5]) begin
                bad++;
                $display("FAIL rnd_instr c=%0d got=%h/%h exp=%h",
                         c, instr, opcode, exp_i);
            end
        end
        start = 1'b0;
        branch = 1'b0;
        lut_we = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_async_reset();
        test_wrap_hazard();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
